// File: rtl/adder_4bit.sv
// Registered 4-bit ripple-carry adder with carry-in and carry-out.
// One full-adder cell per bit; the 5-bit result is captured every cycle.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module adder_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic       cout,
  output logic [3:0] sum
);

  logic [4:0] c;
  logic [3:0] s;

  assign c[0] = cin;

  // c[4] ripples from cin through every cell
  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cout <= 1'b0;
      sum  <= 4'b0000;
    end else begin
      cout <= c[4];
      sum  <= s;
    end
  end

endmodule

// File: tb/tb_adder_4bit.sv
// Self-checking bench for adder_4bit.
// Directed corners, exhaustive sweep, throughput and random ops.
module tb_adder_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       cout;
  logic [3:0] sum;

  int n_tests;
  int n_fail;

  adder_4bit dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .cout (cout),
    .sum  (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [4:0] got,
                     input logic [4:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b_%b expected %b_%b",
               tag, got[4], got[3:0], exp[4], exp[3:0]);
    end
  endtask

  // Reference: plain integer arithmetic, reset forces zero.
  function automatic logic [4:0] model(input logic r,
                                       input int x,
                                       input int y,
                                       input int c);
    int t;
    t = x + y + c;
    return r ? 5'd0 : t[4:0];
  endfunction

  // Present operands, clock once, check the registered result.
  task automatic op(input string tag,
                    input logic r,
                    input logic [3:0] x,
                    input logic [3:0] y,
                    input logic c);
    rst = r;
    a   = x;
    b   = y;
    cin = c;
    @(posedge clk);
    #1;
    chk(tag, {cout, sum}, model(r, int'(x), int'(y), int'(c)));
  endtask

  initial begin
    logic [8:0] v;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    a   = 4'hF;
    b   = 4'hF;
    cin = 1'b1;
    #2;

    op("reset0", 1'b1, 4'hF, 4'hF, 1'b1);
    chk("reset0_const", {cout, sum}, 5'b0_0000);
    op("reset1", 1'b1, 4'hF, 4'hF, 1'b1);
    op("release", 1'b0, 4'hF, 4'hF, 1'b1);
    chk("release_const", {cout, sum}, 5'b1_1111);

    op("ripple_full", 1'b0, 4'b1111, 4'b0000, 1'b1);
    chk("ripple_full_const", {cout, sum}, 5'b1_0000);
    op("ripple_mid", 1'b0, 4'b0111, 4'b0001, 1'b0);
    chk("ripple_mid_const", {cout, sum}, 5'b0_1000);

    op("zero", 1'b0, 4'd0, 4'd0, 1'b0);
    op("max", 1'b0, 4'd15, 4'd15, 1'b0);
    chk("max_const", {cout, sum}, 5'b1_1110);
    op("msb", 1'b0, 4'd8, 4'd8, 1'b0);
    chk("msb_const", {cout, sum}, 5'b1_0000);

    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      if (i == 300) begin
        op("sweep_rst", 1'b1, v[7:4], v[3:0], v[8]);
        chk("sweep_rst_const", {cout, sum}, 5'b0_0000);
      end
      op("sweep", 1'b0, v[7:4], v[3:0], v[8]);
    end

    for (int i = 0; i < 16; i++) begin
      if (i[0] == 1'b0) begin
        op("b2b_even", 1'b0, 4'h5, 4'hA, 1'b1);
        chk("b2b_even_const", {cout, sum}, 5'b1_0000);
      end else begin
        op("b2b_odd", 1'b0, 4'h3, 4'h4, 1'b0);
        chk("b2b_odd_const", {cout, sum}, 5'b0_0111);
      end
    end

    for (int i = 0; i < 300; i++) begin
      op("random", ($urandom_range(0, 15) == 0),
         4'($urandom), 4'($urandom), 1'($urandom));
    end

    // Reset toggled between edges must not disturb the held result.
    op("hold_pre", 1'b0, 4'h9, 4'h4, 1'b1);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("hold_glitch", {cout, sum}, 5'b0_1110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
